udp_rx_frame_fifo: RTL and testbench
====================================

# udp_rx_frame_fifo

Store-and-forward packet FIFO on the UDP receive path, directly downstream of `eth_frame_rx`'s `udp_rx_axis_*` output. Upstream has no `tready`, so the block absorbs every beat. It discards frames flagged bad by `tuser` or frames that overflow the buffer. Only complete, good frames are presented to the user, on an AXI-Stream master with full `tready` backpressure.

## Interface
Parameters:
- `DEPTH_LOG2`, default 9: buffer depth is 2^DEPTH_LOG2 words; each word is 73 bits (tdata 64, tkeep 8, tlast 1).

Ports:
- `rx_axis_aclk`  in  1  sole clock.
- `rx_axis_reset`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  64  frame data from `eth_frame_rx` `udp_rx_axis_tdata`.
- `s_axis_tkeep`  in  8  byte enables.
- `s_axis_tvalid`  in  1  beat valid; cannot be stalled.
- `s_axis_tlast`  in  1  last beat of frame.
- `s_axis_tuser`  in  1  error flag; sampled only on the tlast beat.
- `m_axis_tdata`  out  64  buffered frame data.
- `m_axis_tkeep`  out  8  byte enables.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tlast`  out  1  last beat.
- `m_axis_tready`  in  1  user accepts the beat.
- `drop_err_count`  out  16  frames dropped because `tuser` was set; saturating.
- `drop_ovf_count`  out  16  frames dropped because the buffer overflowed; saturating.

## Operation
- Pointers are DEPTH_LOG2+1 bits wide: `wr_ptr` (speculative), `wr_commit`, and `rd_ptr`.
  - Full: `wr_ptr - rd_ptr == 2^DEPTH_LOG2`.
  - Frame available: `rd_ptr != wr_commit`.
- Write FSM has two states, ACCEPT and DROP.
- ACCEPT, on a valid beat when not full:
  - Write the word at `wr_ptr` and increment `wr_ptr`.
  - On tlast with tuser=0: `wr_commit` takes the post-increment `wr_ptr`.
  - On tlast with tuser=1: `wr_ptr` rolls back to `wr_commit` and `drop_err_count` increments.
- ACCEPT, on a valid beat when full:
  - Roll `wr_ptr` back to `wr_commit`.
  - Increment `drop_ovf_count` once for the frame.
  - If the beat is not tlast, go to DROP; if it is tlast, stay in ACCEPT.
- DROP: discard all beats. A tlast beat returns the FSM to ACCEPT; tuser is ignored for this frame and no further count is added.
- Read side:
  - Memory read has 1-cycle latency and feeds a 2-entry output skid stage.
  - `m_axis_*` is driven from the skid head.
  - `rd_ptr` advances only when a word is fetched into a free skid slot and `rd_ptr != wr_commit`.
- Simultaneous events:
  - Commit and read in the same cycle: both take effect.
  - Rollback never moves below `rd_ptr`, because `wr_commit` is always ≥ `rd_ptr`.
  - Wrap-around is handled by modular pointer arithmetic.
- A frame larger than 2^DEPTH_LOG2 words can never pass; it is always counted as an overflow drop.

## Timing
- Reset state: all pointers 0, FSM in ACCEPT, skid empty, `m_axis_tvalid`=0, `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast`=0, both counters 0.
- Reset in mid-operation: partial and buffered frames are lost. The next beat after reset is treated as the start of a frame.
- Latency: if the tlast beat is sampled at edge N, `wr_commit` updates at N and `m_axis_tvalid` is high after edge N+2.
- Throughput: 1 beat/cycle sustained while `m_axis_tready`=1.
- Handshake:
  - A beat transfers when `m_axis_tvalid && m_axis_tready`.
  - Once `m_axis_tvalid` is asserted, data and tvalid stay stable until accepted.
  - Within a frame, tvalid stays high between beats while stored words remain; a committed frame is always fully present.
- Counters update the cycle after the deciding beat and hold at 0xFFFF once saturated.

## Configuration
- `UDP_RX_FIFO_DROP_STATS_EN`:
  - Defined: both drop counters are implemented as described above.
  - Undefined: counter logic is removed and `drop_err_count`/`drop_ovf_count` are tied to 0.
- Drop behaviour itself is identical either way.

## Structure
- Shared package `udp_stack_pkg`:
  - FIFO word width constant (73).
  - Word field offsets (tdata [63:0], tkeep [71:64], tlast [72]).
  - Write FSM state enum.
- Sub-module `udp_rx_fifo_ram`: simple dual-port RAM, one write port and one registered read port, depth 2^DEPTH_LOG2. It must be inferable as block RAM.

## Test plan
- Good frame: 3 beats, data 0x1111…11 / 0x2222…22 / 0x3333…33, final tkeep 0x0F, tready=1 → identical 3 beats out, `m_axis_tvalid` high 2 cycles after tlast, counters 0.
- Error frame: 4-beat frame with tuser=1 on tlast, followed by a good 2-beat frame → only the 2-beat frame is output and `drop_err_count`=1.
- Overflow: DEPTH_LOG2=4, a 20-beat frame followed by a 4-beat frame → first frame dropped, `drop_ovf_count`=1, the 4-beat frame is output intact.
- Backpressure: 10 back-to-back frames of random length 1–16 with tready toggling randomly at 50% → byte-exact order, no loss, no duplicates.
- Mid-frame reset: reset asserted during beat 2 of a 5-beat frame → all outputs and counters 0 next cycle; the following 3-beat frame passes cleanly.
- Saturation: 65537 error frames → `drop_err_count` holds at 0xFFFF.

Source files
------------

// File: rtl/udp_stack_pkg.sv
// udp_stack_pkg: shared FIFO word layout and write-FSM state type for the UDP RX path.
// Revision 1.0
`default_nettype none

package udp_stack_pkg;

  localparam int FIFO_W    = 73;
  localparam int TDATA_LSB = 0;
  localparam int TDATA_MSB = 63;
  localparam int TKEEP_LSB = 64;
  localparam int TKEEP_MSB = 71;
  localparam int TLAST_BIT = 72;

  typedef enum logic [0:0] {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/udp_rx_fifo_ram.sv
// udp_rx_fifo_ram: simple dual-port RAM, one write port, one registered read port.
// Revision 1.0
`default_nettype none

module udp_rx_fifo_ram
  import udp_stack_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = FIFO_W
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the memory maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/udp_rx_frame_fifo.sv
// udp_rx_frame_fifo: store-and-forward frame FIFO dropping tuser-flagged and overflowing frames.
// Revision 1.0 -- drop counters enabled by macro UDP_RX_FIFO_DROP_STATS_EN.
`default_nettype none

module udp_rx_frame_fifo
  import udp_stack_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        rx_axis_aclk,
  input  logic        rx_axis_reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] drop_err_count,
  output logic [15:0] drop_ovf_count
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  wr_state_e     state_q, state_d;

  logic              full;
  logic              we;
  logic              err_inc;
  logic              ovf_inc;
  logic [FIFO_W-1:0] wword;

  assign full  = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign wword = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    state_d     = state_q;
    we          = 1'b0;
    err_inc     = 1'b0;
    ovf_inc     = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        WR_ACCEPT: begin
          if (!full) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) begin
              if (s_axis_tuser) begin
                wr_ptr_d = wr_commit_q;
                err_inc  = 1'b1;
              end else begin
                wr_commit_d = wr_ptr_q + PTR_ONE;
              end
            end
          end else begin
            // The frame cannot fit: discard what was stored and skip to its end.
            wr_ptr_d = wr_commit_q;
            ovf_inc  = 1'b1;
            if (!s_axis_tlast) begin
              state_d = WR_DROP;
            end
          end
        end
        default: begin
          if (s_axis_tlast) begin
            state_d = WR_ACCEPT;
          end
        end
      endcase
    end
  end

  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic [FIFO_W-1:0] skid_q [2];
  logic [FIFO_W-1:0] skid_d [2];
  logic [FIFO_W-1:0] rdata;
  logic              pop;
  logic              fetch;
  logic [1:0]        used;
  logic [1:0]        base;

  assign pop   = (skid_cnt_q != 2'd0) && m_axis_tready;
  // Slots committed after this cycle's pop, counting the word still in the RAM read register.
  assign used  = skid_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign fetch = (rd_ptr_q != wr_commit_q) && (used < 2'd2);
  assign base  = skid_cnt_q - {1'b0, pop};

  always_comb begin
    rd_ptr_d   = fetch ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_pend_d  = fetch;
    skid_d[0]  = skid_q[0];
    skid_d[1]  = skid_q[1];
    skid_cnt_d = skid_cnt_q;
    if (pop) begin
      skid_d[0]  = skid_q[1];
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (rd_pend_q) begin
      if (base == 2'd0) begin
        skid_d[0] = rdata;
      end else begin
        skid_d[1] = rdata;
      end
      skid_cnt_d = base + 2'd1;
    end
  end

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_reset) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      state_q     <= WR_ACCEPT;
      rd_pend_q   <= 1'b0;
      skid_cnt_q  <= 2'd0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      skid_cnt_q  <= skid_cnt_d;
      skid_q[0]   <= skid_d[0];
      skid_q[1]   <= skid_d[1];
    end
  end

  udp_rx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (FIFO_W)
  ) u_ram (
    .clk_i   (rx_axis_aclk),
    .we_i    (we),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wword),
    .re_i    (fetch),
    .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (rdata)
  );

  assign m_axis_tvalid = (skid_cnt_q != 2'd0);
  assign m_axis_tdata  = skid_q[0][TDATA_MSB:TDATA_LSB];
  assign m_axis_tkeep  = skid_q[0][TKEEP_MSB:TKEEP_LSB];
  assign m_axis_tlast  = skid_q[0][TLAST_BIT];

`ifdef UDP_RX_FIFO_DROP_STATS_EN
  logic [15:0] err_cnt_q;
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_reset) begin
      err_cnt_q <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else begin
      if (err_inc && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (ovf_inc && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
    end
  end

  assign drop_err_count = err_cnt_q;
  assign drop_ovf_count = ovf_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = err_inc ^ ovf_inc;
  assign drop_err_count = 16'd0;
  assign drop_ovf_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_udp_rx_frame_fifo.sv
// tb_udp_rx_frame_fifo: scoreboard bench for udp_rx_frame_fifo with a 16-word buffer.
// Revision 1.0
`default_nettype none

module tb_udp_rx_frame_fifo;

  localparam int D   = 4;
  localparam int CAP = 16;
`ifdef UDP_RX_FIFO_DROP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] err_cnt;
  logic [15:0] ovf_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [72:0] exp_q[$];
  int          exp_err = 0;
  int          exp_ovf = 0;
  bit          bp_en = 1'b0;

  always #5 clk = ~clk;

  udp_rx_frame_fifo #(.DEPTH_LOG2(D)) dut (
    .rx_axis_aclk   (clk),
    .rx_axis_reset  (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .drop_err_count (err_cnt),
    .drop_ovf_count (ovf_cnt)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tready changes at the falling edge; a beat seen valid&&ready here transfers on the next rise.
  always @(negedge clk) begin
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && m_tvalid === 1'b1 && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 80'({m_tlast, m_tkeep, m_tdata}), 80'(0));
      end else begin
        chk("beat", 80'({m_tlast, m_tkeep, m_tdata}), 80'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input bit last, input bit user);
    @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = last;
    s_tuser  = user;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // Overflow prediction assumes the buffer is empty when an oversize frame starts.
  task automatic send_frame(input int len, input bit user, input bit pat, input logic [7:0] last_keep);
    logic [72:0] words[$];
    logic [63:0] d;
    logic [7:0]  k;
    logic [7:0]  b8;
    for (int b = 0; b < len; b++) begin
      b8 = 8'((b + 1) * 17);
      d  = pat ? {8{b8}} : {$urandom, $urandom};
      k  = (b == len - 1) ? last_keep : 8'hFF;
      drive_beat(d, k, b == len - 1, user);
      words.push_back({(b == len - 1) ? 1'b1 : 1'b0, k, d});
    end
    if (len > CAP) begin
      if (exp_ovf < 65535) exp_ovf++;
    end else if (user) begin
      if (exp_err < 65535) exp_err++;
    end else begin
      foreach (words[i]) exp_q.push_back(words[i]);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 80'(exp_q.size()), 80'(0));
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_err"}, 80'(err_cnt), 80'(STATS ? exp_err : 0));
    chk({tag, "_ovf"}, 80'(ovf_cnt), 80'(STATS ? exp_ovf : 0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 80'(m_tvalid), 80'(0));
    chk({tag, "_tdata"},  80'(m_tdata),  80'(0));
    chk({tag, "_tkeep"},  80'(m_tkeep),  80'(0));
    chk({tag, "_tlast"},  80'(m_tlast),  80'(0));
    chk_counts(tag);
  endtask

  initial begin
    int len;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Patterned 3-beat frame and its commit-to-valid latency.
    send_frame(3, 1'b0, 1'b1, 8'h0F);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("lat_n", 80'(m_tvalid), 80'(0));
    @(posedge clk);
    #1;
    chk("lat_n1", 80'(m_tvalid), 80'(0));
    @(posedge clk);
    #1;
    chk("lat_n2", 80'(m_tvalid), 80'(1));
    drain("good_drain");
    chk_counts("good");

    // Error frame followed immediately by a good frame.
    send_frame(4, 1'b1, 1'b0, 8'h3F);
    send_frame(2, 1'b0, 1'b0, 8'h01);
    idle();
    drain("err_drain");
    chk_counts("err");

    // Oversize frame, then a frame that must survive intact.
    send_frame(20, 1'b0, 1'b0, 8'hFF);
    send_frame(4, 1'b0, 1'b0, 8'h07);
    idle();
    drain("ovf_drain");
    chk_counts("ovf");

    // Exactly-full frame passes; one word more overflows on its tlast beat.
    send_frame(CAP, 1'b0, 1'b0, 8'h1F);
    idle();
    drain("full16_drain");
    send_frame(CAP + 1, 1'b1, 1'b0, 8'hFF);
    send_frame(2, 1'b0, 1'b0, 8'h03);
    idle();
    drain("ovf17_drain");
    chk_counts("ovf17");

    // Random lengths under random backpressure.
    bp_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 16);
      if (exp_q.size() + len > CAP) begin
        idle();
        n = 0;
        while (exp_q.size() + len > CAP && n < 3000) begin
          @(posedge clk);
          n++;
        end
        chk("bp_space", 80'(exp_q.size() + len > CAP), 80'(0));
      end
      send_frame(len, 1'b0, 1'b0, 8'(1 << $urandom_range(0, 7)) | 8'h01);
    end
    idle();
    drain("bp_drain");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    chk_counts("bp");

    // Reset lands on beat 2 of a 5-beat frame.
    drive_beat(64'hA5A5_0001_A5A5_0001, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    s_tdata = 64'hA5A5_0002_A5A5_0002;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_err = 0;
    exp_ovf = 0;
    chk_outputs_zero("midrst");
    send_frame(3, 1'b0, 1'b0, 8'h7F);
    idle();
    drain("midrst_drain");
    chk_counts("midrst");

`ifdef UDP_RX_FIFO_DROP_STATS_EN
    for (int i = 0; i < 65537; i++) begin
      drive_beat(64'(i), 8'hFF, 1'b1, 1'b1);
      if (exp_err < 65535) exp_err++;
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("sat_err", 80'(err_cnt), 80'(16'hFFFF));
    chk_counts("sat");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
